// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_wb_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int RD_W     = 5;

  localparam logic [RD_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
  } wb_entry_t;

  localparam wb_entry_t WB_NONE = '{rd: REG_ZERO, value: '0};

  function automatic logic rd_writes(input logic [RD_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; head is readable combinationally
// so an entry accepted in one cycle can be selected in the next.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  wb_entry_t                  push_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t       mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            do_push, do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Merges two pipe writebacks and a buffered long-latency stream onto the two
// register-file write ports, and tracks destinations awaiting long-latency data.
module regfile_wb_sched
  import regfile_wb_pkg::*;
#(
  parameter int SUPPORT_DUAL_ISSUE = 1,
  parameter int FIFO_DEPTH         = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [RD_W-1:0]     wb0_rd_i,
  input  logic [XLEN-1:0]     wb0_value_i,
  input  logic [RD_W-1:0]     wb1_rd_i,
  input  logic [XLEN-1:0]     wb1_value_i,
  input  logic                ll_valid_i,
  input  logic [RD_W-1:0]     ll_rd_i,
  input  logic [XLEN-1:0]     ll_value_i,
  output logic                ll_ready_o,
  input  logic                alloc_i,
  input  logic [RD_W-1:0]     alloc_rd_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [RD_W-1:0]     rd0_o,
  output logic [XLEN-1:0]     rd0_value_o,
  output logic [RD_W-1:0]     rd1_o,
  output logic [XLEN-1:0]     rd1_value_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         wb1_eff;
  wb_entry_t         fifo_head;
  wb_entry_t         fifo_in;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic              head_hazard, drain_p0, drain_p1;
  wb_entry_t         port0_reg, port0_next;
  wb_entry_t         port1_reg, port1_next;
  logic [NUM_REGS-1:1] busy_reg, busy_next;

  // Single-issue builds never see pipe1, so port 1 is reserved for the FIFO.
  generate
    if (SUPPORT_DUAL_ISSUE != 0) begin : g_dual
      assign wb1_eff = '{rd: wb1_rd_i, value: wb1_value_i};
    end else begin : g_single
      assign wb1_eff = WB_NONE;
    end
  endgenerate

  assign ll_ready_o = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_in    = '{rd: ll_rd_i, value: ll_value_i};
  // Results for x0 are accepted but never occupy an entry.
  assign fifo_push  = ll_valid_i && !fifo_full && rd_writes(ll_rd_i);

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A head matching a same-cycle pipe write waits so the pipe value lands alone.
  assign head_hazard = (rd_writes(wb0_rd_i) && fifo_head.rd == wb0_rd_i) ||
                       (rd_writes(wb1_eff.rd) && fifo_head.rd == wb1_eff.rd);

  assign drain_p0 = !fifo_empty && !head_hazard && !rd_writes(wb0_rd_i);
  assign drain_p1 = !fifo_empty && !head_hazard && rd_writes(wb0_rd_i) &&
                    !rd_writes(wb1_eff.rd);
  assign fifo_pop = drain_p0 || drain_p1;

  always_comb begin
    port0_next = WB_NONE;
    port1_next = WB_NONE;
    if (rd_writes(wb0_rd_i)) begin
      port0_next = '{rd: wb0_rd_i, value: wb0_value_i};
    end else if (drain_p0) begin
      port0_next = fifo_head;
    end
    if (rd_writes(wb1_eff.rd)) begin
      port1_next = wb1_eff;
    end else if (drain_p1) begin
      port1_next = fifo_head;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port0_reg <= WB_NONE;
      port1_reg <= WB_NONE;
    end else begin
      port0_reg <= port0_next;
      port1_reg <= port1_next;
    end
  end

  // Per-register scoreboard bit; a new allocation outranks a same-cycle drain.
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_bit, clr_bit;
      assign set_bit = alloc_i && (alloc_rd_i == RD_W'(gi));
      assign clr_bit = fifo_pop && (fifo_head.rd == RD_W'(gi));

      always_comb begin
        busy_next[gi] = busy_reg[gi];
        if (set_bit)      busy_next[gi] = 1'b1;
        else if (clr_bit) busy_next[gi] = 1'b0;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_reg[gi] <= 1'b0;
        else         busy_reg[gi] <= busy_next[gi];
      end
    end
  endgenerate

  assign busy_o      = {busy_reg, 1'b0};
  assign rd0_o       = port0_reg.rd;
  assign rd0_value_o = port0_reg.value;
  assign rd1_o       = port1_reg.rd;
  assign rd1_value_o = port1_reg.value;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  wb0_rd, wb1_rd, ll_rd, alloc_rd;
  logic [31:0] wb0_value, wb1_value, ll_value;
  logic        ll_valid, alloc;
  logic        ll_ready;
  logic [31:0] busy;
  logic [4:0]  rd0, rd1;
  logic [31:0] rd0_value, rd1_value;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wb0_rd_i    (wb0_rd),
    .wb0_value_i (wb0_value),
    .wb1_rd_i    (wb1_rd),
    .wb1_value_i (wb1_value),
    .ll_valid_i  (ll_valid),
    .ll_rd_i     (ll_rd),
    .ll_value_i  (ll_value),
    .ll_ready_o  (ll_ready),
    .alloc_i     (alloc),
    .alloc_rd_i  (alloc_rd),
    .busy_o      (busy),
    .rd0_o       (rd0),
    .rd0_value_o (rd0_value),
    .rd1_o       (rd1),
    .rd1_value_o (rd1_value)
  );

  task automatic idle_inputs();
    wb0_rd = 0; wb0_value = 0; wb1_rd = 0; wb1_value = 0;
    ll_valid = 0; ll_rd = 0; ll_value = 0; alloc = 0; alloc_rd = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd0_value !== 32'd0) begin bad++; $display("FAIL reset_port0 got=%0d/%h exp=0/0", rd0, rd0_value); end
    total++; if (rd1 !== 5'd0 || rd1_value !== 32'd0) begin bad++; $display("FAIL reset_port1 got=%0d/%h exp=0/0", rd1, rd1_value); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ll_ready); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    rst_ni = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_pipe_only();
    wb0_rd = 5'd3; wb0_value = 32'h11; wb1_rd = 5'd4; wb1_value = 32'h22;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL pipe_ready0 got=%b exp=1", ll_ready); end
    @(negedge clk);
    total++; if (rd0 !== 5'd3 || rd0_value !== 32'h11) begin bad++; $display("FAIL pipe_port0 got=%0d/%h exp=3/11", rd0, rd0_value); end
    total++; if (rd1 !== 5'd4 || rd1_value !== 32'h22) begin bad++; $display("FAIL pipe_port1 got=%0d/%h exp=4/22", rd1, rd1_value); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL pipe_ready1 got=%b exp=1", ll_ready); end
    idle_inputs();
    @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd0_value !== 32'd0 || rd1 !== 5'd0 || rd1_value !== 32'd0) begin
      bad++; $display("FAIL pipe_empty got=%0d/%h %0d/%h exp=0/0 0/0", rd0, rd0_value, rd1, rd1_value); end
    $display("pipe: wb0=(3,11) wb1=(4,22) -> rd0=%0d/%h rd1=%0d/%h", 3, 32'h11, 4, 32'h22);
  endtask

  task automatic test_drain_port0();
    alloc = 1'b1; alloc_rd = 5'd7;
    @(negedge clk);
    alloc = 1'b0;
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL alloc_busy7 got=%b exp=1", busy[7]); end
    ll_valid = 1'b1; ll_rd = 5'd7; ll_value = 32'hDEAD;
    @(negedge clk);
    ll_valid = 1'b0;
    total++; if (rd0 !== 5'd0) begin bad++; $display("FAIL ll_early got=%0d exp=0", rd0); end
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL busy7_held got=%b exp=1", busy[7]); end
    @(negedge clk);
    total++; if (rd0 !== 5'd7 || rd0_value !== 32'hDEAD) begin bad++; $display("FAIL ll_port0 got=%0d/%h exp=7/dead", rd0, rd0_value); end
    total++; if (busy[7] !== 1'b0) begin bad++; $display("FAIL busy7_clear got=%b exp=0", busy[7]); end
    $display("drain0: ll (7,dead) -> rd0 two cycles later, busy[7] cleared");
  endtask

  task automatic test_fill_backpressure();
    wb0_rd = 5'd1; wb0_value = 32'hA1; wb1_rd = 5'd2; wb1_value = 32'hB2;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_value = 32'h100;
    @(negedge clk);
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL fill_ready1 got=%b exp=1", ll_ready); end
    ll_rd = 5'd11; ll_value = 32'h101;
    @(negedge clk);
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL fill_ready2 got=%b exp=0", ll_ready); end
    ll_rd = 5'd12; ll_value = 32'h102;
    @(negedge clk);
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL fill_ready3 got=%b exp=0", ll_ready); end
    total++; if (rd0 !== 5'd1 || rd1 !== 5'd2) begin bad++; $display("FAIL fill_pipes got=%0d %0d exp=1 2", rd0, rd1); end
    ll_valid = 1'b0; wb1_rd = 5'd0; wb1_value = 32'd0;
    @(negedge clk);
    total++; if (rd1 !== 5'd10 || rd1_value !== 32'h100) begin bad++; $display("FAIL fill_out0 got=%0d/%h exp=10/100", rd1, rd1_value); end
    total++; if (rd0 !== 5'd1 || rd0_value !== 32'hA1) begin bad++; $display("FAIL fill_wb0 got=%0d/%h exp=1/a1", rd0, rd0_value); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL fill_ready4 got=%b exp=1", ll_ready); end
    @(negedge clk);
    total++; if (rd1 !== 5'd11 || rd1_value !== 32'h101) begin bad++; $display("FAIL fill_out1 got=%0d/%h exp=11/101", rd1, rd1_value); end
    wb0_rd = 5'd0; wb0_value = 32'd0;
    @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd1 !== 5'd0) begin bad++; $display("FAIL fill_drained got=%0d %0d exp=0 0", rd0, rd1); end
    $display("fill: two accepts, ready low, drained 10 then 11 on port1");
  endtask

  task automatic test_hazard_hold();
    ll_valid = 1'b1; ll_rd = 5'd5; ll_value = 32'h55;
    @(negedge clk);
    ll_valid = 1'b0; wb1_rd = 5'd5; wb1_value = 32'h99;
    @(negedge clk);
    total++; if (rd0 !== 5'd0) begin bad++; $display("FAIL hazard_port0 got=%0d exp=0", rd0); end
    total++; if (rd1 !== 5'd5 || rd1_value !== 32'h99) begin bad++; $display("FAIL hazard_port1 got=%0d/%h exp=5/99", rd1, rd1_value); end
    wb1_rd = 5'd0; wb1_value = 32'd0;
    @(negedge clk);
    total++; if (rd0 !== 5'd5 || rd0_value !== 32'h55) begin bad++; $display("FAIL hazard_release got=%0d/%h exp=5/55", rd0, rd0_value); end
    total++; if (rd1 !== 5'd0) begin bad++; $display("FAIL hazard_port1_idle got=%0d exp=0", rd1); end
    $display("hazard: head rd=5 held behind wb1 rd=5, drained next cycle");
  endtask

  task automatic test_discard_x0();
    ll_valid = 1'b1; ll_rd = 5'd0; ll_value = 32'h77;
    @(negedge clk);
    ll_valid = 1'b0;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", ll_ready); end
    @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd0_value !== 32'd0 || rd1 !== 5'd0) begin
      bad++; $display("FAIL x0_no_write got=%0d/%h %0d exp=0/0 0", rd0, rd0_value, rd1); end
    $display("discard: ll rd=0 accepted without an entry");
  endtask

  task automatic test_collision();
    alloc = 1'b1; alloc_rd = 5'd9;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_value = 32'h9;
    @(negedge clk);
    ll_valid = 1'b0;
    total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL coll_set got=%b exp=1", busy[9]); end
    @(negedge clk);
    alloc = 1'b0;
    total++; if (rd0 !== 5'd9 || rd0_value !== 32'h9) begin bad++; $display("FAIL coll_drain got=%0d/%h exp=9/9", rd0, rd0_value); end
    total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL coll_busy9 got=%b exp=1", busy[9]); end
    @(negedge clk);
    $display("collision: alloc 9 with drain of 9, busy[9] stays set");
  endtask

  task automatic test_async_reset();
    wb0_rd = 5'd1; wb0_value = 32'h1; wb1_rd = 5'd2; wb1_value = 32'h2;
    ll_valid = 1'b1; ll_rd = 5'd20; ll_value = 32'h200; alloc = 1'b1; alloc_rd = 5'd20;
    @(negedge clk);
    ll_rd = 5'd21; ll_value = 32'h201; alloc = 1'b0;
    @(negedge clk);
    ll_valid = 1'b0;
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL ar_full got=%b exp=0", ll_ready); end
    total++; if (busy[20] !== 1'b1) begin bad++; $display("FAIL ar_busy20 got=%b exp=1", busy[20]); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (rd0 !== 5'd0 || rd0_value !== 32'd0 || rd1 !== 5'd0 || rd1_value !== 32'd0) begin
      bad++; $display("FAIL ar_ports got=%0d/%h %0d/%h exp=0/0 0/0", rd0, rd0_value, rd1, rd1_value); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", ll_ready); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL ar_busy got=%h exp=0", busy); end
    idle_inputs();
    #1 rst_ni = 1'b1;
    @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd1 !== 5'd0) begin bad++; $display("FAIL ar_stale1 got=%0d %0d exp=0 0", rd0, rd1); end
    @(negedge clk);
    total++; if (rd0 !== 5'd0 || rd1 !== 5'd0 || ll_ready !== 1'b1) begin
      bad++; $display("FAIL ar_stale2 got=%0d %0d rdy=%b exp=0 0 rdy=1", rd0, rd1, ll_ready); end
    $display("async reset: queue flushed, no stale writes after release");
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_drain_port0();
    test_fill_backpressure();
    test_hazard_hold();
    test_discard_x0();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler that sits in front of the dual-write-port flop register file. It merges three writeback sources onto the register file's two write ports `rd0`/`rd1`: the two in-order pipe results and a long-latency stream of load and divide results. A small FIFO holds long-latency results until a write port is idle. A pending-destination scoreboard tells issue logic which registers are still awaiting a long-latency write.

## Interface
Parameters:
- `SUPPORT_DUAL_ISSUE`, default 1. When 0, `wb1_*` is ignored and port 1 carries only FIFO traffic.
- `FIFO_DEPTH`, default 2. Long-latency buffer entries; must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- `wb0_rd_i`  in  5  pipe0 destination; 0 = no write
- `wb0_value_i`  in  32  pipe0 result
- `wb1_rd_i`  in  5  pipe1 destination; 0 = no write
- `wb1_value_i`  in  32  pipe1 result
- `ll_valid_i`  in  1  long-latency result valid
- `ll_rd_i`  in  5  long-latency destination
- `ll_value_i`  in  32  long-latency result
- `ll_ready_o`  out  1  FIFO can accept
- `alloc_i`  in  1  issue allocates a long-latency destination
- `alloc_rd_i`  in  5  allocated destination
- `busy_o`  out  32  pending-destination bitmap; bit 0 is constant 0
- `rd0_o`, `rd0_value_o`  out  5/32  to register file write port 0
- `rd1_o`, `rd1_value_o`  out  5/32  to register file write port 1

## Operation
- Pipe writes are never stalled. Each cycle, port 0 is given to `wb0` and port 1 to `wb1`, provided the source's rd is nonzero.
- **FIFO drain:**
  - At most one entry drains per cycle, from the head.
  - It takes port 0 if `wb0_rd_i`==0; otherwise port 1 if that port is free (`wb1_rd_i`==0, or `SUPPORT_DUAL_ISSUE`=0).
  - If neither port is free, the head stays in the FIFO.
- **Hazard hold:** the head also stays if its rd equals a nonzero `wb0_rd_i` or `wb1_rd_i` in the same cycle. Ordering is otherwise guaranteed upstream via `busy_o`.
- **Enqueue:** occurs on `ll_valid_i && ll_ready_o`. If `ll_rd_i`==0 the result is accepted and discarded, and no entry is created.
- **`ll_ready_o`:** equals `count < FIFO_DEPTH`, taken from the registered count. Enqueue and dequeue in the same cycle are legal, including at count == FIFO_DEPTH-1. With a full FIFO, a dequeue does not raise ready until the next cycle.
- **Scoreboard:**
  - `alloc_i` with nonzero `alloc_rd_i` sets `busy[alloc_rd_i]`.
  - A FIFO entry selected onto a port clears `busy[rd]`.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - `alloc_rd_i`==0 is ignored.
- **Empty port:** a port carrying nothing outputs rd=0 and value=0.

## Timing
- **Reset:** all outputs go to 0 (`rd0_o`, `rd1_o`, both values, `busy_o`), except `ll_ready_o`, which is 1. The FIFO is emptied. Reset asserted mid-operation discards FIFO contents and busy bits immediately (asynchronous).
- **Registered outputs:** `rd*_o` and `rd*_value_o` are registered.
- **Pipe latency:** a pipe write presented in cycle N appears on the port in cycle N+1. The register file captures it at the end of N+1.
- **Long-latency latency:** a result accepted in cycle N can be selected no earlier than N+1, and appears on the port at N+2.
- **`busy_o` timing:** `busy_o` is registered. A bit clears in the same cycle its entry appears on a port. A bit set by `alloc_i` in cycle N is visible in N+1.
- **Pointer wrap:** FIFO pointers wrap modulo `FIFO_DEPTH`. The count width is clog2(`FIFO_DEPTH`)+1.

## Structure
- **Package `regfile_wb_pkg`:**
  - `wb_entry_t` {rd[4:0], value[31:0]}
  - `REG_ZERO` = 5'd0
  - `XLEN` = 32
- **Sub-module `wb_fifo`:** parameterised synchronous FIFO of `wb_entry_t`, with push/pop/full/empty/count. It uses the same asynchronous active-low reset.
- **Top level:** the port selection, hazard hold and scoreboard live in `regfile_wb_sched`.

## Test plan
- **Pipe only, no conflict:** after reset, drive wb0=(3, 0x11), wb1=(4, 0x22) in cycle 1 → cycle 2 shows rd0_o=3/0x11 and rd1_o=4/0x22; `ll_ready_o`=1 throughout.
- **FIFO drain via port 0:**
  - Drive alloc rd=7 → `busy_o[7]`=1 next cycle.
  - Accept ll (7, 0xDEAD) with both pipes idle → rd0_o=7/0xDEAD two cycles later, and `busy_o[7]` clears in that same cycle.
- **Fill and backpressure:**
  - Hold wb0=(1,x) and wb1=(2,x) every cycle and push 3 ll results → `ll_ready_o` drops after 2 accepts.
  - Release wb1 → one entry per cycle exits on port 1 in FIFO order.
- **Hazard hold:** FIFO head rd=5 while wb1_rd=5 and wb0 idle → head is held; rd0_o=0 and rd1_o=5 carries the pipe value. The head drains next cycle.
- **Scoreboard set/clear collision:** alloc rd=9 in the same cycle an rd=9 entry is selected → `busy_o[9]` remains 1.
- **Asynchronous reset mid-operation:** with 2 entries queued, pulse `rst_ni` low between clock edges → outputs go to 0 at once, `ll_ready_o`=1, `busy_o`=0, and no stale write appears after release.
